// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parametrised serial sequence detector.
package seq_det_pkg;

    localparam int unsigned DefaultN       = 4;
    localparam logic [3:0]  DefaultPattern = 4'b0110;
    localparam int unsigned DefaultCntW    = 8;

    // Increment that holds at max instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] count, input logic [31:0] max);
        return (count >= max) ? max : count + 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; a clear in the same cycle as an increment yields 1.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int unsigned W = DefaultCntW
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    localparam logic [31:0] MaxCount = 32'((64'd1 << W) - 64'd1);

    logic [W-1:0] count_d;

    always_comb begin
        count_d = count;
        if (clr) begin
            count_d = inc ? W'(1) : '0;
        end else if (inc) begin
            count_d = W'(sat_inc(32'(count), MaxCount));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            count <= count_d;
        end
    end

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with programmable pattern, valid qualifier, selectable
// overlap, Mealy match output, registered match flag and saturating match count.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int unsigned N       = DefaultN,
    parameter logic [N-1:0] PATTERN = N'(DefaultPattern),
    parameter int unsigned CNT_W   = DefaultCntW
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             x,
    input  logic             x_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [N-1:0]     pat_in,
    input  logic             cnt_clr,
    output logic             z,
    output logic             z_q,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int unsigned  FillW   = $clog2(N);
    localparam logic [FillW-1:0] FillMax = FillW'(N - 1);

    logic [N-1:0]     pat_q, pat_d;
    logic [N-2:0]     hist_q, hist_d;
    logic [FillW-1:0] fill_q, fill_d;
    logic [N-1:0]     window;
    logic             accept;
    logic             match;

    always_comb begin
        window = {hist_q, x};
        accept = reset_n & x_valid & ~pat_load;
        match  = accept && (fill_q == FillMax) && (window == pat_q);
        z      = match;

        pat_d  = pat_q;
        hist_d = hist_q;
        fill_d = fill_q;

        if (pat_load) begin
            pat_d  = pat_in;
            hist_d = '0;
            fill_d = '0;
        end else if (accept) begin
            hist_d = window[N-2:0];
            if (match) begin
                // Non-overlapping restarts the fill so the next match needs N fresh bits.
                fill_d = overlap ? FillMax : '0;
            end else if (fill_q != FillMax) begin
                fill_d = fill_q + FillW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pat_q  <= PATTERN;
            hist_q <= '0;
            fill_q <= '0;
            z_q    <= 1'b0;
        end else begin
            pat_q  <= pat_d;
            hist_q <= hist_d;
            fill_q <= fill_d;
            z_q    <= z;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_match_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (match),
        .clr     (cnt_clr),
        .count   (match_cnt)
    );

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param with a queue-based reference model checked every cycle.
module tb_seq_detect_param;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         x = 1'b0;
    logic         x_valid = 1'b0;
    logic         overlap = 1'b0;
    logic         pat_load = 1'b0;
    logic [N-1:0] pat_in = '0;
    logic         cnt_clr = 1'b0;

    logic         z, z_q, z2, z_q2;
    logic [7:0]   cnt8;
    logic [1:0]   cnt2;

    int checks = 0;
    int errors = 0;

    logic         ovl_n = 1'b0;
    logic [N-1:0] pat_n = 4'b0110;
    logic [31:0]  zs;

    always #5 clk = ~clk;

    seq_detect_param dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .x         (x),
        .x_valid   (x_valid),
        .overlap   (overlap),
        .pat_load  (pat_load),
        .pat_in    (pat_in),
        .cnt_clr   (cnt_clr),
        .z         (z),
        .z_q       (z_q),
        .match_cnt (cnt8)
    );

    seq_detect_param #(
        .CNT_W (2)
    ) dut_small (
        .clk       (clk),
        .reset_n   (reset_n),
        .x         (x),
        .x_valid   (x_valid),
        .overlap   (overlap),
        .pat_load  (pat_load),
        .pat_in    (pat_in),
        .cnt_clr   (cnt_clr),
        .z         (z2),
        .z_q       (z_q2),
        .match_cnt (cnt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the accepted bits since the last restart, kept as a queue.
    bit           q[$];
    logic [N-1:0] m_pat = 4'b0110;
    logic         m_zq = 1'b0;
    int           m_cnt8 = 0;
    int           m_cnt2 = 0;

    always @(negedge clk) begin
        logic [N-1:0] w;
        logic         exp_z;
        exp_z = 1'b0;
        if (reset_n && x_valid && !pat_load && q.size() == N - 1) begin
            for (int i = 0; i < N - 1; i++) w[N-1-i] = q[i];
            w[0]  = x;
            exp_z = (w == m_pat);
        end
        check("z", {31'd0, z}, {31'd0, exp_z});
        check("z_small", {31'd0, z2}, {31'd0, exp_z});
        check("z_q", {31'd0, z_q}, {31'd0, m_zq});
        check("z_q_small", {31'd0, z_q2}, {31'd0, m_zq});
        check("match_cnt", {24'd0, cnt8}, m_cnt8);
        check("match_cnt_small", {30'd0, cnt2}, m_cnt2);

        // Advance to the state expected after the coming rising edge.
        if (!reset_n) begin
            m_pat  = 4'b0110;
            q.delete();
            m_cnt8 = 0;
            m_cnt2 = 0;
            m_zq   = 1'b0;
        end else begin
            m_zq = exp_z;
            if (cnt_clr) begin
                m_cnt8 = exp_z ? 1 : 0;
                m_cnt2 = exp_z ? 1 : 0;
            end else if (exp_z) begin
                m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
                m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
            end
            if (pat_load) begin
                m_pat = pat_in;
                q.delete();
            end else if (x_valid) begin
                if (exp_z && !overlap) begin
                    q.delete();
                end else begin
                    q.push_back(x);
                    if (q.size() > N - 1) void'(q.pop_front());
                end
            end
        end
    end

    task automatic step(input logic rst, input logic vi, input logic xi, input logic ld,
                        input logic clr);
        @(posedge clk);
        #1;
        reset_n  = rst;
        x_valid  = vi;
        x        = xi;
        pat_load = ld;
        cnt_clr  = clr;
        overlap  = ovl_n;
        pat_in   = pat_n;
        @(negedge clk);
        #1;
        zs = {zs[30:0], z};
    endtask

    task automatic feed(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, 1'b1, bits[i], 1'b0, 1'b0);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_cnt", {24'd0, cnt8}, 32'd0);
        check("reset_zq", {31'd0, z_q}, 32'd0);

        // Non-overlapping on 0110110
        ovl_n = 1'b0;
        zs = '0;
        feed(32'b0110110, 7);
        check("nonovl_z", zs[6:0], 32'b0001000);
        idle();
        check("nonovl_cnt", {24'd0, cnt8}, 32'd1);

        // Overlapping on the same stream
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ovl_n = 1'b1;
        zs = '0;
        feed(32'b0110110, 7);
        check("ovl_z", zs[6:0], 32'b0001001);
        idle();
        check("ovl_zq", {31'd0, z_q}, 32'd1);
        check("ovl_cnt", {24'd0, cnt8}, 32'd2);

        // Gaps of three invalid cycles between bits, x toggled while invalid
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ovl_n = 1'b0;
        zs = '0;
        for (int i = 3; i >= 0; i--) begin
            logic [3:0] b;
            b = 4'b0110;
            step(1'b1, 1'b1, b[i], 1'b0, 1'b0);
            if (i != 0) for (int k = 0; k < 3; k++) step(1'b1, 1'b0, ~b[i], 1'b0, 1'b0);
        end
        check("gap_z", zs[12:0], 32'b0000000000001);
        idle();
        check("gap_cnt", {24'd0, cnt8}, 32'd1);

        // Load 1111 with a valid sample and counter clear in the same cycle
        ovl_n = 1'b1;
        pat_n = 4'b1111;
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check("load_z", {31'd0, z}, 32'd0);
        zs = '0;
        feed(32'b111111, 6);
        check("ones_z", zs[5:0], 32'b000111);
        idle();
        check("ones_cnt", {24'd0, cnt8}, 32'd3);

        // Reload 0110, then reset mid-pattern
        ovl_n = 1'b0;
        pat_n = 4'b0110;
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        zs = '0;
        feed(32'b011, 3);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        feed(32'b0, 1);
        feed(32'b0110, 4);
        check("rst_mid_z", zs[8:0], 32'b000000001);

        // Counter saturation on the 2-bit instance
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        ovl_n = 1'b1;
        zs = '0;
        feed(32'h6DB6, 16);
        check("sat_z", zs[15:0], 32'h1249);
        idle();
        check("sat_cnt_small", {30'd0, cnt2}, 32'd3);
        check("sat_cnt", {24'd0, cnt8}, 32'd5);

        // Clear coincident with a match, then clear alone
        feed(32'b11, 2);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("clr_match_z", {31'd0, z}, 32'd1);
        idle();
        check("clr_match_cnt_small", {30'd0, cnt2}, 32'd1);
        check("clr_match_cnt", {24'd0, cnt8}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        check("clr_alone_cnt_small", {30'd0, cnt2}, 32'd0);
        check("clr_alone_cnt", {24'd0, cnt8}, 32'd0);

        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
